// File: rtl/seq_cla_multiplier.sv
// rtl/seq_cla_multiplier.sv - 16x16 unsigned shift-add multiplier time-sharing one cla16x16 adder
// Optional macro SEQ_MULT_ZERO_BYPASS_EN: zero operands skip the RUN steps.

module cla16x16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  logic [15:0] g;
  logic [15:0] p;
  logic [16:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  // Two-level lookahead: 4-bit group generate/propagate, then ripple inside each group
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    gc[0] = cin;
    for (int k = 0; k < 4; k++) begin
      gc[k+1] = gg[k] | (gp[k] & gc[k]);
    end
    for (int k = 0; k < 4; k++) begin
      c[4*k] = gc[k];
      for (int i = 0; i < 3; i++) begin
        c[4*k+i+1] = g[4*k+i] | (p[4*k+i] & c[4*k+i]);
      end
    end
    c[16] = gc[4];
  end

  assign sum  = p ^ c[15:0];
  assign cout = c[16];
endmodule

module seq_cla_multiplier #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);
  generate
    if (WIDTH != 16) begin : g_bad_width
      $error("seq_cla_multiplier: WIDTH must be 16");
    end
    if ((2 ** CNT_W) <= WIDTH) begin : g_bad_cnt
      $error("seq_cla_multiplier: CNT_W too small for WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sum_lo;
  logic             sum_co;

  cla16x16 u_add (
    .a    (hi),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (sum_lo),
    .cout (sum_co)
  );

  assign product = {hi, lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      mcand     <= '0;
      hi        <= '0;
      lo        <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand    <= a;
            hi       <= '0;
            lo       <= b;
            cnt      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
`ifdef SEQ_MULT_ZERO_BYPASS_EN
            if (a == '0 || b == '0) begin
              lo        <= '0;
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
          end
        end
        RUN: begin
          // The 17-bit sum shifts in whole, so the adder carry-out lands in hi[15]
          if (lo[0]) begin
            {hi, lo} <= {sum_co, sum_lo, lo[WIDTH-1:1]};
          end else begin
            {hi, lo} <= {1'b0, hi, lo[WIDTH-1:1]};
          end
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cnt       <= '0;
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_seq_cla_multiplier.sv
// tb/tb_seq_cla_multiplier.sv - directed self-checking bench for seq_cla_multiplier

module tb_seq_cla_multiplier;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;
  logic        busy;

  int n_cmp;
  int n_err;
  int n_in;
  int n_out;

`ifdef SEQ_MULT_ZERO_BYPASS_EN
  localparam int LAT_ZERO = 1;
`else
  localparam int LAT_ZERO = 17;
`endif
  localparam int LAT_FULL = 17;

  seq_cla_multiplier #(.WIDTH(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) n_out++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic [31:0] exp, input int stall, input int exp_lat);
    int waitc;
    int lat;
    waitc = 0;
    while (!in_ready && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    check("in_ready_before_accept", in_ready, 1);
    a         = ta;
    b         = tb_v;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    n_in++;
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    while (!out_valid && lat < 40) begin
      if (stall > 0) in_valid = lat[0];
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", lat, exp_lat);
    check("product", product, exp);
    check("busy_done", busy, 1);
    for (int i = 0; i < stall; i++) begin
      in_valid = i[0];
      @(negedge clk);
      check("stall_out_valid", out_valid, 1);
      check("stall_product", product, exp);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_after_hs", out_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
    check("busy_after_hs", busy, 0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    n_cmp = 0;
    n_err = 0;
    n_in = 0;
    n_out = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_product", product, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op(16'd3, 16'd5, 32'h0000000F, 0, LAT_FULL);
    do_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 0, LAT_FULL);
    do_op(16'h8000, 16'h0002, 32'h00010000, 0, LAT_FULL);
    do_op(16'h1234, 16'h0001, 32'h00001234, 2, LAT_FULL);
    do_op(16'h0001, 16'h8000, 32'h00008000, 0, LAT_FULL);
    do_op(16'h00FF, 16'h0100, 32'h0000FF00, 0, LAT_FULL);
    do_op(16'hABCD, 16'h1234, 32'h0C374FA4, 40, LAT_FULL);

    // Abort mid-RUN
    a = 16'd100;
    b = 16'd200;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("busy_mid_run", busy, 1);
    check("in_ready_mid_run", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    check("abort_product", product, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(16'd7, 16'd9, 32'd63, 0, LAT_FULL);

    do_op(16'h0000, 16'h1234, 32'h0, 0, LAT_ZERO);
    do_op(16'h5678, 16'h0000, 32'h0, 1, LAT_ZERO);

    for (int k = 0; k < 30; k++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      do_op(ra, rb, 32'(ra) * 32'(rb), int'($urandom_range(0, 3)),
            (ra == 16'h0 || rb == 16'h0) ? LAT_ZERO : LAT_FULL);
    end

    repeat (2) @(negedge clk);
    check("count_in_eq_out", n_out, n_in);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
